// File: rtl/ecc_mem_scheduler_pkg.sv
// Shared types and default sizing for the ECC memory scheduler.
// Port, op, strobe and ECC class encodings are common to the top and its arbiter.
package ecc_mem_scheduler_pkg;

    localparam int unsigned D_W   = 32;
    localparam int unsigned A_W   = 2;
    localparam int unsigned W_LAT = 4;
    localparam int unsigned R_LAT = 5;

    typedef enum logic {PORTA = 1'b0, PORTB = 1'b1} port;
    typedef enum logic {RD = 1'b0, WR = 1'b1} we_type;
    typedef enum logic {EN_DEASSERT = 1'b0, EN_ASSERT = 1'b1} en_type;
    typedef enum logic [1:0] {ZERO = 2'd0, ONE = 2'd1, TWO = 2'd2} error_type;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} sched_state;

    function automatic logic [1:0] port_onehot(port p);
        return (p == PORTA) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port that did not win last time is chosen.
module rr_arb2
    import ecc_mem_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output port        win,
    output logic       valid
);

    port last_gnt;

    always_comb begin
        win = PORTA;
        case (req)
            2'b01:   win = PORTA;
            2'b10:   win = PORTB;
            2'b11:   win = (last_gnt == PORTB) ? PORTA : PORTB;
            default: win = PORTA;
        endcase
    end

    assign valid = |req;

    // PORTB as reset history so PORTA wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= PORTB;
        end else if (upd && valid) begin
            last_gnt <= win;
        end
    end

endmodule

// File: rtl/ecc_mem_scheduler.sv
// Shares one fixed-latency single-port ECC memory core between two requesters,
// one command at a time, returning read data and ECC class to the granted port.
module ecc_mem_scheduler
    import ecc_mem_scheduler_pkg::*;
#(
    parameter int unsigned D_W   = ecc_mem_scheduler_pkg::D_W,
    parameter int unsigned A_W   = ecc_mem_scheduler_pkg::A_W,
    parameter int unsigned W_LAT = ecc_mem_scheduler_pkg::W_LAT,
    parameter int unsigned R_LAT = ecc_mem_scheduler_pkg::R_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    input  we_type         we [2],
    input  logic [A_W-1:0] addr [2],
    input  logic [D_W-1:0] wdata [2],
    output logic [1:0]     gnt,
    output logic [1:0]     done,
    output logic [D_W-1:0] rdata,
    output error_type      err,
    output logic           busy,
    output logic [7:0]     dbe_cnt,
    output en_type         mem_en,
    output we_type         mem_we,
    output logic [A_W-1:0] mem_addr,
    output logic [D_W-1:0] mem_wdata,
    input  logic [D_W-1:0] mem_rdata,
    input  error_type      mem_err
);

    localparam int unsigned MAX_LAT = (W_LAT > R_LAT) ? W_LAT : R_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(W_LAT - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(R_LAT - 1);

    sched_state       state;
    port              cur;
    logic [CNT_W-1:0] cnt;
    port              win;
    logic             win_valid;
    logic             arb_upd;

    assign arb_upd = (state == S_IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .upd   (arb_upd),
        .win   (win),
        .valid (win_valid)
    );

    // mem_we/mem_addr/mem_wdata double as the command registers and hold through S_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur       <= PORTA;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            err       <= ZERO;
            busy      <= 1'b0;
            dbe_cnt   <= '0;
            mem_en    <= EN_DEASSERT;
            mem_we    <= RD;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt    <= '0;
            done   <= '0;
            mem_en <= EN_DEASSERT;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        state     <= S_ISSUE;
                        cur       <= win;
                        gnt       <= port_onehot(win);
                        busy      <= 1'b1;
                        mem_en    <= EN_ASSERT;
                        mem_we    <= we[win];
                        mem_addr  <= addr[win];
                        mem_wdata <= wdata[win];
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    cnt   <= (mem_we == WR) ? W_LOAD : R_LOAD;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                        done  <= port_onehot(cur);
                        if (mem_we == RD) begin
                            rdata <= mem_rdata;
                            err   <= mem_err;
                            if (mem_err == TWO && dbe_cnt != 8'hFF) begin
                                dbe_cnt <= dbe_cnt + 8'd1;
                            end
                        end else begin
                            err <= ZERO;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_mem_scheduler.sv
// Directed bench for ecc_mem_scheduler: default latencies on one instance and
// W_LAT=R_LAT=1 on a second, each with a negedge-driven core model.
module tb_ecc_mem_scheduler;
    import ecc_mem_scheduler_pkg::*;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Instance 1: default latencies.
    logic [1:0]  req;
    we_type      we_i [2];
    logic [1:0]  addr_i [2];
    logic [31:0] wdata_i [2];
    logic [1:0]  gnt, done;
    logic [31:0] rdata;
    error_type   err;
    logic        busy;
    logic [7:0]  dbe_cnt;
    en_type      mem_en;
    we_type      mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    error_type   mem_err;

    // Instance 2: single-cycle latencies.
    logic [1:0]  req2;
    we_type      we2 [2];
    logic [1:0]  addr2 [2];
    logic [31:0] wdata2 [2];
    logic [1:0]  gnt2, done2;
    logic [31:0] rdata2;
    error_type   err2;
    logic        busy2;
    logic [7:0]  dbe2;
    en_type      men2;
    we_type      mwe2;
    logic [1:0]  maddr2;
    logic [31:0] mwdata2;
    logic [31:0] mrdata2;
    error_type   merr2;

    ecc_mem_scheduler u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we_i), .addr(addr_i), .wdata(wdata_i),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .busy(busy), .dbe_cnt(dbe_cnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    ecc_mem_scheduler #(.W_LAT(1), .R_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .gnt(gnt2), .done(done2), .rdata(rdata2), .err(err2), .busy(busy2), .dbe_cnt(dbe2),
        .mem_en(men2), .mem_we(mwe2), .mem_addr(maddr2), .mem_wdata(mwdata2),
        .mem_rdata(mrdata2), .mem_err(merr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core models: data valid only in cycle I+LAT, poisoned otherwise.
    logic [31:0] arr1 [4];
    logic [31:0] arr2 [4];
    error_type   err_force;
    int          k1 = -1;
    int          k2 = -1;
    we_type      op1, op2;
    logic [1:0]  a1, a2;

    always @(negedge clk) begin
        if (mem_en == EN_ASSERT) begin
            k1 = 0; a1 = mem_addr; op1 = mem_we;
            if (mem_we == WR) arr1[mem_addr] = mem_wdata;
        end else if (k1 >= 0 && k1 < 20) begin
            k1++;
        end
        if (k1 == 5 && op1 == RD) begin
            mem_rdata = arr1[a1]; mem_err = err_force;
        end else begin
            mem_rdata = 32'hBAD0BAD0; mem_err = ONE;
        end
    end

    always @(negedge clk) begin
        if (men2 == EN_ASSERT) begin
            k2 = 0; a2 = maddr2; op2 = mwe2;
            if (mwe2 == WR) arr2[maddr2] = mwdata2;
        end else if (k2 >= 0 && k2 < 20) begin
            k2++;
        end
        if (k2 == 1 && op2 == RD) begin
            mrdata2 = arr2[a2]; merr2 = ZERO;
        end else begin
            mrdata2 = 32'hBAD0BAD0; merr2 = ONE;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          r_lat, r_en;
    logic [31:0] r_rd, r_wdata;
    error_type   r_err;
    we_type      r_we;
    logic [1:0]  r_addr;

    task automatic do_op(input int p, input we_type op, input logic [1:0] a,
                         input logic [31:0] d);
        int t0;
        bit seen;
        we_i[p] = op; addr_i[p] = a; wdata_i[p] = d; req[p] = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt[p]) begin seen = 1; break; end
        end
        req[p] = 1'b0;
        if (!seen) begin check("gnt_timeout", 0, 1); return; end
        t0 = cyc; r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata;
        r_en = (mem_en == EN_ASSERT) ? 1 : 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_en == EN_ASSERT) r_en++;
            if (done[p]) begin seen = 1; break; end
        end
        if (!seen) begin check("done_timeout", 0, 1); return; end
        r_lat = cyc - t0; r_rd = rdata; r_err = err;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy && !busy2) begin ok = 1; break; end
        end
        check("idle_timeout", 32'(ok), 1);
    endtask

    int  gp[$];
    int  gc[$];
    int  dc[$];
    int  t0, nd;
    bit  seen;

    initial begin
        rst = 1'b1; req = '0; req2 = '0; err_force = ZERO;
        for (int i = 0; i < 2; i++) begin
            we_i[i] = RD; addr_i[i] = '0; wdata_i[i] = '0;
            we2[i] = RD; addr2[i] = '0; wdata2[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin arr1[i] = 32'h0; arr2[i] = 32'h0; end
        arr1[2] = 32'hDEADBEEF;
        arr2[3] = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_en", 32'(mem_en), 32'(EN_DEASSERT));
        check("rst_err", 32'(err), 32'(ZERO));
        check("rst_dbe", 32'(dbe_cnt), 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: PORTA read
        do_op(0, RD, 2'd2, 32'h0);
        check("t1_lat", 32'(r_lat), 6);
        check("t1_mem_we", 32'(r_we), 32'(RD));
        check("t1_mem_addr", 32'(r_addr), 2);
        check("t1_rdata", r_rd, 32'hDEADBEEF);
        check("t1_err", 32'(r_err), 32'(ZERO));

        // 2: PORTB write, then read it back
        do_op(1, WR, 2'd1, 32'h12345678);
        check("t2_lat", 32'(r_lat), 5);
        check("t2_en_cycles", 32'(r_en), 1);
        check("t2_mem_we", 32'(r_we), 32'(WR));
        check("t2_mem_wdata", r_wdata, 32'h12345678);
        check("t2_err", 32'(r_err), 32'(ZERO));
        check("t2_rdata_held", r_rd, 32'hDEADBEEF);
        do_op(0, RD, 2'd1, 32'h0);
        check("t2_readback", r_rd, 32'h12345678);

        // 3: both requests held from reset
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        we_i[0] = RD; we_i[1] = RD; addr_i[0] = 2'd2; addr_i[1] = 2'd2;
        req = 2'b11;
        for (int i = 0; i < 60 && gp.size() < 4; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin gp.push_back((gnt == 2'b10) ? 1 : 0); gc.push_back(cyc); end
            if (done != 2'b00) dc.push_back(cyc);
        end
        req = 2'b00;
        check("t3_ngnt", 32'(gp.size()), 4);
        check("t3_ndone", 32'(dc.size() >= 3), 1);
        if (gp.size() == 4 && dc.size() >= 3) begin
            for (int i = 0; i < 4; i++) check("t3_order", 32'(gp[i]), 32'(i % 2));
            for (int i = 0; i < 3; i++) check("t3_done_to_gnt", 32'(gc[i+1] - dc[i]), 2);
        end
        wait_idle();

        // 4: double-bit errors and dbe_cnt saturation
        err_force = TWO;
        for (int i = 0; i < 3; i++) begin
            do_op(0, RD, 2'd2, 32'h0);
            check("t4_err", 32'(r_err), 32'(TWO));
            check("t4_rdata", r_rd, 32'hDEADBEEF);
        end
        check("t4_dbe3", 32'(dbe_cnt), 3);
        do_op(1, WR, 2'd0, 32'h55AA55AA);
        check("t4_wr_err", 32'(r_err), 32'(ZERO));
        check("t4_wr_dbe", 32'(dbe_cnt), 3);
        for (int i = 0; i < 252; i++) do_op(0, RD, 2'd2, 32'h0);
        check("t4_dbe255", 32'(dbe_cnt), 255);
        for (int i = 0; i < 5; i++) do_op(1, RD, 2'd2, 32'h0);
        check("t4_dbe_sat", 32'(dbe_cnt), 255);
        err_force = ZERO;

        // 5: reset in cycle I+2 of a PORTA read
        we_i[0] = RD; addr_i[0] = 2'd2; req[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt[0]) begin seen = 1; break; end
        end
        req[0] = 1'b0;
        check("t5_gnt_seen", 32'(seen), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_gnt", 32'(gnt), 0);
        check("t5_done", 32'(done), 0);
        check("t5_mem_en", 32'(mem_en), 32'(EN_DEASSERT));
        check("t5_mem_addr", 32'(mem_addr), 0);
        check("t5_dbe", 32'(dbe_cnt), 0);
        check("t5_err", 32'(err), 32'(ZERO));
        check("t5_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done != 2'b00) nd++;
        end
        check("t5_no_done", 32'(nd), 0);
        req = 2'b11;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin seen = 1; break; end
        end
        check("t5_first_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        wait_idle();

        // 6: W_LAT=R_LAT=1 instance
        we2[0] = RD; addr2[0] = 2'd3; req2[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt2[0]) begin seen = 1; break; end
        end
        req2[0] = 1'b0;
        check("t6_gnt_seen", 32'(seen), 1);
        t0 = cyc;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done2[0]) begin seen = 1; break; end
        end
        check("t6_done_seen", 32'(seen), 1);
        check("t6_lat", 32'(cyc - t0), 2);
        check("t6_rdata", rdata2, 32'hCAFEF00D);
        check("t6_err", 32'(err2), 32'(ZERO));
        we2[1] = RD; addr2[1] = 2'd3;
        gc.delete();
        req2 = 2'b11;
        for (int i = 0; i < 30 && gc.size() < 3; i++) begin
            @(negedge clk);
            if (gnt2 != 2'b00) gc.push_back(cyc);
        end
        req2 = 2'b00;
        check("t6_ngnt", 32'(gc.size()), 3);
        if (gc.size() == 3) begin
            check("t6_spacing0", 32'(gc[1] - gc[0]), 4);
            check("t6_spacing1", 32'(gc[2] - gc[1]), 4);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
